alu_issue_queue: RTL and testbench

ALU_ISSUE_QUEUE -- requirements
Module: alu_issue_queue

---
 rtl/alu_pkg.sv | 55 +++++
 rtl/alu_scoreboard.sv | 35 +++
 rtl/alu_issue_queue.sv | 113 +++++++++++
 tb/tb_alu_issue_queue.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcode constants, instruction field positions and queue entry types
// for the ALU issue queue.
package alu_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP32   = 7'b0111011;
  localparam logic [6:0] OPC_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_IMM32  = 7'b0011011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam int OPC_LSB = 0;
  localparam int RD_LSB  = 7;
  localparam int RS1_LSB = 15;
  localparam int RS2_LSB = 20;

  // Entries always hold a full 64-bit PC; narrower XLEN builds use the low bits.
  localparam int PC_W = 64;

  typedef struct packed {
    logic [31:0]     inst;
    logic [PC_W-1:0] pc;
  } entry_t;

  typedef struct packed {
    logic use_rs1;
    logic use_rs2;
    logic use_rd;
    logic illegal;
  } dec_t;

  function automatic dec_t decode(input logic [31:0] inst);
    dec_t d;
    d = '0;
    case (inst[OPC_LSB +: 7])
      OPC_OP, OPC_OP32: begin
        d.use_rs1 = 1'b1;
        d.use_rs2 = 1'b1;
        d.use_rd  = 1'b1;
      end
      OPC_IMM, OPC_IMM32: begin
        d.use_rs1 = 1'b1;
        d.use_rd  = 1'b1;
      end
      OPC_LUI, OPC_AUIPC: begin
        d.use_rd  = 1'b1;
      end
      default: begin
        d.illegal = 1'b1;
      end
    endcase
    return d;
  endfunction

endpackage

// File: rtl/alu_scoreboard.sv
// Per-register busy bits: set on issue, cleared on writeback; x0 never busy.
module alu_scoreboard
  import alu_pkg::*;
#(
  parameter int NREG = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            set_en,
  input  logic [4:0]      set_idx,
  input  logic            clr_en,
  input  logic [4:0]      clr_idx,
  output logic [NREG-1:0] busy
);

  logic [NREG-1:0] busy_q, busy_d;

  // Set wins over clear on the same index: a new producer outlives the old one.
  always_comb begin
    busy_d = busy_q;
    for (int i = 1; i < NREG; i++) begin
      if (clr_en && (clr_idx == 5'(i))) busy_d[i] = 1'b0;
      if (set_en && (set_idx == 5'(i))) busy_d[i] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) busy_q <= '0;
    else          busy_q <= busy_d;
  end

  assign busy = busy_q;

endmodule

// File: rtl/alu_issue_queue.sv
// In-order ALU issue queue: circular FIFO whose head issues only when its
// source and destination registers are free in the scoreboard.
module alu_issue_queue
  import alu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int XLEN  = 64,
  parameter int NREG  = 32
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   enq_valid,
  output logic                   enq_ready,
  input  logic [31:0]            enq_inst,
  input  logic [XLEN-1:0]        enq_pc,
  output logic                   iss_valid,
  input  logic                   iss_ready,
  output logic [31:0]            iss_inst,
  output logic [XLEN-1:0]        iss_pc,
  output logic                   iss_illegal,
  input  logic                   wb_valid,
  input  logic [4:0]             wb_rd_idx,
  input  logic                   flush,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [PW-1:0]   head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]   count_q, count_d;
  logic            rdy_q;
  entry_t          mem_q [DEPTH];

  entry_t          head_ent;
  dec_t            head_dec;
  logic [4:0]      rd, rs1, rs2;
  logic [NREG-1:0] busy;
  logic            empty, hazard, enq_fire, iss_fire, set_en;

  assign empty    = (count_q == '0);
  assign head_ent = mem_q[head_q];
  assign head_dec = decode(head_ent.inst);
  assign rd       = head_ent.inst[RD_LSB  +: 5];
  assign rs1      = head_ent.inst[RS1_LSB +: 5];
  assign rs2      = head_ent.inst[RS2_LSB +: 5];

  // Hazards use registered busy bits only; a writeback frees issue next cycle.
  assign hazard = (head_dec.use_rs1 && busy[rs1])
               || (head_dec.use_rs2 && busy[rs2])
               || (head_dec.use_rd && (rd != 5'd0) && busy[rd]);

  assign iss_valid   = !empty && !flush && !hazard;
  assign enq_ready   = rdy_q && (count_q < DEPTH_C) && !flush;
  assign iss_inst    = empty ? '0 : head_ent.inst;
  assign iss_pc      = empty ? '0 : head_ent.pc[XLEN-1:0];
  assign iss_illegal = !empty && head_dec.illegal;
  assign count       = count_q;

  assign enq_fire = enq_valid && enq_ready;
  assign iss_fire = iss_valid && iss_ready;
  assign set_en   = iss_fire && head_dec.use_rd && (rd != 5'd0);

  alu_scoreboard #(.NREG(NREG)) u_scoreboard (
    .clk     (clk),
    .reset_n (reset_n),
    .set_en  (set_en),
    .set_idx (rd),
    .clr_en  (wb_valid),
    .clr_idx (wb_rd_idx),
    .busy    (busy)
  );

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (enq_fire) tail_d = tail_q + 1'b1;
      if (iss_fire) head_d = head_q + 1'b1;
      case ({enq_fire, iss_fire})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // rdy_q holds enq_ready low for the first cycle after reset release.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      rdy_q   <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      rdy_q   <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (enq_fire) mem_q[tail_q] <= '{inst: enq_inst, pc: PC_W'(enq_pc)};
  end

endmodule

// File: tb/tb_alu_issue_queue.sv
// Directed bench for alu_issue_queue: RAW/WAW stalls, full, flush, illegal,
// x0 handling and mid-run reset, with hand-computed expectations.
module tb_alu_issue_queue;

  localparam int DEPTH = 4;
  localparam int XLEN  = 64;
  localparam int NREG  = 32;

  localparam logic [31:0] ADDI1  = 32'h00500093;
  localparam logic [31:0] ADD2   = 32'h00108133;
  localparam logic [31:0] ECALL  = 32'h00000073;
  localparam logic [31:0] LD1    = 32'h00003083;
  localparam logic [31:0] ADDI3A = 32'h00100193;
  localparam logic [31:0] ADDI3B = 32'h00200193;
  localparam logic [31:0] NOP    = 32'h00000013;
  localparam logic [31:0] ADDI5  = 32'h00700293;
  localparam logic [31:0] ADD6   = 32'h00528333;
  localparam logic [31:0] LUI7   = 32'h000013B7;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            enq_valid;
  logic            enq_ready;
  logic [31:0]     enq_inst;
  logic [XLEN-1:0] enq_pc;
  logic            iss_valid;
  logic            iss_ready;
  logic [31:0]     iss_inst;
  logic [XLEN-1:0] iss_pc;
  logic            iss_illegal;
  logic            wb_valid;
  logic [4:0]      wb_rd_idx;
  logic            flush;
  logic [$clog2(DEPTH):0] count;

  int checks = 0;
  int errors = 0;

  alu_issue_queue #(.DEPTH(DEPTH), .XLEN(XLEN), .NREG(NREG)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .enq_valid   (enq_valid),
    .enq_ready   (enq_ready),
    .enq_inst    (enq_inst),
    .enq_pc      (enq_pc),
    .iss_valid   (iss_valid),
    .iss_ready   (iss_ready),
    .iss_inst    (iss_inst),
    .iss_pc      (iss_pc),
    .iss_illegal (iss_illegal),
    .wb_valid    (wb_valid),
    .wb_rd_idx   (wb_rd_idx),
    .flush       (flush),
    .count       (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [31:0] i, input logic [63:0] p);
    enq_valid = 1'b1;
    enq_inst  = i;
    enq_pc    = p;
    tick();
    enq_valid = 1'b0;
  endtask

  task automatic wb(input logic [4:0] idx);
    wb_valid  = 1'b1;
    wb_rd_idx = idx;
    tick();
    wb_valid  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "bench did not finish");
  end

  initial begin
    logic [63:0] exp_pc [4];
    exp_pc = '{64'h208, 64'h20c, 64'h210, 64'h214};

    reset_n = 1'b0; enq_valid = 1'b0; enq_inst = '0; enq_pc = '0;
    iss_ready = 1'b0; wb_valid = 1'b0; wb_rd_idx = '0; flush = 1'b0;

    // reset
    tick(); tick();
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_enq_ready", 64'(enq_ready), 64'd0);
    chk("rst_iss_valid", 64'(iss_valid), 64'd0);
    chk("rst_iss_inst", 64'(iss_inst), 64'd0);
    reset_n = 1'b1;
    #2 chk("rdy_lag", 64'(enq_ready), 64'd0);
    tick();
    #2 chk("rdy_up", 64'(enq_ready), 64'd1);

    // RAW on x1
    iss_ready = 1'b1;
    enq_valid = 1'b1; enq_inst = ADDI1; enq_pc = 64'h100;
    #2 chk("lat_empty", 64'(iss_valid), 64'd0);
    tick();
    enq_inst = ADD2; enq_pc = 64'h104;
    #2 chk("raw_hd_valid", 64'(iss_valid), 64'd1);
    chk("raw_hd_pc", iss_pc, 64'h100);
    tick();
    enq_valid = 1'b0;
    #2 chk("raw_stall", 64'(iss_valid), 64'd0);
    chk("raw_count", 64'(count), 64'd1);
    tick();
    wb_valid = 1'b1; wb_rd_idx = 5'd1;
    #2 chk("raw_nobypass", 64'(iss_valid), 64'd0);
    tick();
    wb_valid = 1'b0;
    #2 chk("raw_release", 64'(iss_valid), 64'd1);
    chk("raw_inst", 64'(iss_inst), 64'(ADD2));
    tick();
    #2 chk("raw_drained", 64'(count), 64'd0);
    wb(5'd2);

    // full, no bypass, simultaneous enq+issue, wrap
    iss_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      enq_valid = 1'b1;
      enq_inst  = 32'h00000013 | (32'(k + 1) << 20);
      enq_pc    = 64'h200 + 64'(4 * k);
      tick();
    end
    enq_valid = 1'b0;
    #2 chk("full_count", 64'(count), 64'd4);
    chk("full_enq_ready", 64'(enq_ready), 64'd0);
    chk("full_head_inst", 64'(iss_inst), 64'h00100013);
    tick();
    #2 chk("hold_pc", iss_pc, 64'h200);
    iss_ready = 1'b1;
    enq_valid = 1'b1; enq_inst = 32'h00500013; enq_pc = 64'h210;
    #2 chk("full_nobypass", 64'(enq_ready), 64'd0);
    tick();
    #2 chk("full_pop_count", 64'(count), 64'd3);
    chk("full_pop_pc", iss_pc, 64'h204);
    tick();
    #2 chk("enq_iss_count", 64'(count), 64'd3);
    chk("enq_iss_pc", iss_pc, 64'h208);
    iss_ready = 1'b0;
    enq_inst = 32'h00600013; enq_pc = 64'h214;
    tick();
    enq_valid = 1'b0;
    #2 chk("refill_count", 64'(count), 64'd4);
    iss_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("drain_pc", iss_pc, exp_pc[k]);
      tick();
      #2;
    end
    chk("drain_empty", 64'(count), 64'd0);

    // flush with x1 still in flight
    put(ADDI1, 64'h300);
    tick();
    iss_ready = 1'b0;
    put(ADD2, 64'h304);
    put(NOP, 64'h308);
    put(NOP, 64'h30c);
    #2 chk("fl_pre_count", 64'(count), 64'd3);
    chk("fl_pre_stall", 64'(iss_valid), 64'd0);
    flush = 1'b1;
    enq_valid = 1'b1; enq_inst = NOP; enq_pc = 64'h310;
    #2 chk("fl_enq_ready", 64'(enq_ready), 64'd0);
    tick();
    flush = 1'b0; enq_valid = 1'b0;
    #2 chk("fl_count", 64'(count), 64'd0);
    chk("fl_iss_valid", 64'(iss_valid), 64'd0);
    iss_ready = 1'b1;
    put(ADD2, 64'h320);
    #2 chk("fl_busy_kept", 64'(iss_valid), 64'd0);
    wb(5'd1);
    #2 chk("fl_wb_clear", 64'(iss_valid), 64'd1);
    chk("fl_wb_pc", iss_pc, 64'h320);
    tick();
    wb(5'd2);

    // illegal opcodes set no busy bit
    iss_ready = 1'b0;
    put(ECALL, 64'h400);
    #2 chk("ill_valid", 64'(iss_valid), 64'd1);
    chk("ill_flag", 64'(iss_illegal), 64'd1);
    iss_ready = 1'b1;
    tick();
    put(LD1, 64'h404);
    #2 chk("ill_ld_flag", 64'(iss_illegal), 64'd1);
    put(ADD2, 64'h408);
    #2 chk("ill_no_busy", 64'(iss_valid), 64'd1);
    chk("ill_next_pc", iss_pc, 64'h408);
    chk("ill_next_flag", 64'(iss_illegal), 64'd0);
    tick();
    wb(5'd2);

    // WAW on x3
    put(ADDI3A, 64'h500);
    put(ADDI3B, 64'h504);
    #2 chk("waw_stall", 64'(iss_valid), 64'd0);
    wb_valid = 1'b1; wb_rd_idx = 5'd3;
    #2 chk("waw_nobypass", 64'(iss_valid), 64'd0);
    tick();
    wb_valid = 1'b0;
    #2 chk("waw_release", 64'(iss_valid), 64'd1);
    chk("waw_pc", iss_pc, 64'h504);
    tick();
    wb(5'd3);

    // x0 writers issue back-to-back
    put(NOP, 64'h600);
    put(NOP, 64'h604);
    #2 chk("x0_b2b", 64'(iss_valid), 64'd1);
    chk("x0_pc", iss_pc, 64'h604);
    tick();
    #2 chk("x0_empty", 64'(count), 64'd0);

    // reset mid-run with x5 busy
    put(ADDI5, 64'h700);
    tick();
    iss_ready = 1'b0;
    put(ADD6, 64'h704);
    put(NOP, 64'h708);
    #2 chk("mr_count", 64'(count), 64'd2);
    chk("mr_stall", 64'(iss_valid), 64'd0);
    reset_n = 1'b0;
    #1 chk("mr_async_count", 64'(count), 64'd0);
    chk("mr_async_ready", 64'(enq_ready), 64'd0);
    chk("mr_async_pc", iss_pc, 64'd0);
    tick(); tick();
    reset_n = 1'b1;
    tick();
    #2 chk("mr_ready", 64'(enq_ready), 64'd1);
    iss_ready = 1'b1;
    put(ADD6, 64'h710);
    #2 chk("mr_busy_clr", 64'(iss_valid), 64'd1);
    chk("mr_pc", iss_pc, 64'h710);
    tick();
    #2 chk("mr_empty", 64'(count), 64'd0);

    // rd-only class
    put(LUI7, 64'h720);
    #2 chk("lui_valid", 64'(iss_valid), 64'd1);
    chk("lui_legal", 64'(iss_illegal), 64'd0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
